reg_write_arbiter: RTL and testbench

REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

---
 rtl/reg_write_arbiter.sv | 126 ++++++++++++
 tb/tb_reg_write_arbiter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/reg_write_arbiter.sv
// Two-requester write arbiter for a register file write port.
// After reset it zero-fills every register, one address per cycle. It then
// arbitrates ALU and load writebacks onto a single registered write port,
// using round-robin priority when both requesters are valid.
//
// Handshake: a transfer on requester n happens in a cycle where ReqnValid
// and ReqnReady are both 1 at the rising edge. Ready is combinational and
// depends only on the two valids, the state and the round-robin pointer.
// A requester that holds Valid without Ready keeps Addr/Data stable.
// The accepted write appears on the port one cycle later.
module reg_write_arbiter #(
  parameter int WordLen     = 32,
  parameter int AddrLen     = 5,
  parameter int ZeroProtect = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               Req0Valid,
  input  logic [AddrLen-1:0] Req0Addr,
  input  logic [WordLen-1:0] Req0Data,
  input  logic               Req1Valid,
  input  logic [AddrLen-1:0] Req1Addr,
  input  logic [WordLen-1:0] Req1Data,
  output logic               Req0Ready,
  output logic               Req1Ready,
  output logic [AddrLen-1:0] WriteReg,
  output logic [WordLen-1:0] WriteData,
  output logic               RegWrite,
  output logic               InitDone,
  output logic               DbgState   // 0 = INIT, 1 = RUN
);

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  // The counter has one extra bit so it can say "every address is cleared".
  localparam logic [AddrLen:0] ClearEnd = {1'b1, {AddrLen{1'b0}}};

  state_t             state, stateNext;
  logic [AddrLen:0]   clearCnt, clearCntNext;
  logic               rrPtr, rrPtrNext;
  logic               regWriteNext;
  logic [AddrLen-1:0] writeRegNext;
  logic [WordLen-1:0] writeDataNext;

  assign InitDone = (state == RUN);
  assign DbgState = state;

  // State, clear counter and round-robin pointer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= INIT;
      clearCnt <= '0;
      rrPtr    <= 1'b0;
    end else begin
      state    <= stateNext;
      clearCnt <= clearCntNext;
      rrPtr    <= rrPtrNext;
    end
  end

  // Next-state logic, grant logic and next write-port values
  always_comb begin
    stateNext     = state;
    clearCntNext  = clearCnt;
    rrPtrNext     = rrPtr;
    Req0Ready     = 1'b0;
    Req1Ready     = 1'b0;
    regWriteNext  = 1'b0;
    writeRegNext  = WriteReg;
    writeDataNext = WriteData;
    case (state)
      INIT: begin
        // After the last clear write has been issued, spend one more cycle
        // here so the move to RUN lines up with the edge after that write.
        if (clearCnt == ClearEnd) begin
          stateNext = RUN;
        end else begin
          regWriteNext  = 1'b1;
          writeRegNext  = clearCnt[AddrLen-1:0];
          writeDataNext = '0;
          clearCntNext  = clearCnt + 1'b1;
        end
      end
      RUN: begin
        Req0Ready = Req0Valid & (~Req1Valid | ~rrPtr);
        Req1Ready = Req1Valid & (~Req0Valid |  rrPtr);
        // The pointer favours the loser, and only moves after a contended cycle.
        if (Req0Valid && Req1Valid) begin
          rrPtrNext = ~rrPtr;
        end
        // A write to address 0 is acknowledged but dropped when protected.
        if (Req0Ready) begin
          if (!(ZeroProtect != 0 && Req0Addr == '0)) begin
            regWriteNext  = 1'b1;
            writeRegNext  = Req0Addr;
            writeDataNext = Req0Data;
          end
        end else if (Req1Ready) begin
          if (!(ZeroProtect != 0 && Req1Addr == '0)) begin
            regWriteNext  = 1'b1;
            writeRegNext  = Req1Addr;
            writeDataNext = Req1Data;
          end
        end
      end
      default: stateNext = INIT;
    endcase
  end

  // Registered write port. Reset drops any write that was pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      RegWrite  <= 1'b0;
      WriteReg  <= '0;
      WriteData <= '0;
    end else begin
      RegWrite  <= regWriteNext;
      WriteReg  <= writeRegNext;
      WriteData <= writeDataNext;
    end
  end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter with WordLen=4, AddrLen=2 and ZeroProtect=1.
module tb_reg_write_arbiter;

  localparam int W = 4;
  localparam int A = 2;

  logic         clk;
  logic         rst_n;
  logic         req0_valid, req1_valid;
  logic [A-1:0] req0_addr, req1_addr;
  logic [W-1:0] req0_data, req1_data;
  logic         req0_ready, req1_ready;
  logic [A-1:0] write_reg;
  logic [W-1:0] write_data;
  logic         reg_write;
  logic         init_done;
  logic         dbg_state;

  int checks   = 0;
  int failures = 0;

  logic [A-1:0] exp_q[$];

  typedef struct packed {
    logic         v0;
    logic [A-1:0] a0;
    logic [W-1:0] d0;
    logic         v1;
    logic [A-1:0] a1;
    logic [W-1:0] d1;
    logic         r0;
    logic         r1;
    logic         wr;
    logic [A-1:0] wreg;
    logic [W-1:0] wdata;
    logic         done;
  } vec_t;

  vec_t vecs[$];

  reg_write_arbiter #(.WordLen(W), .AddrLen(A), .ZeroProtect(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .Req0Valid (req0_valid),
    .Req0Addr  (req0_addr),
    .Req0Data  (req0_data),
    .Req1Valid (req1_valid),
    .Req1Addr  (req1_addr),
    .Req1Data  (req1_data),
    .Req0Ready (req0_ready),
    .Req1Ready (req1_ready),
    .WriteReg  (write_reg),
    .WriteData (write_data),
    .RegWrite  (reg_write),
    .InitDone  (init_done),
    .DbgState  (dbg_state)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #20000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic v0, input logic [A-1:0] a0, input logic [W-1:0] d0,
                              input logic v1, input logic [A-1:0] a1, input logic [W-1:0] d1,
                              input logic r0, input logic r1, input logic wr,
                              input logic [A-1:0] wreg, input logic [W-1:0] wdata,
                              input logic done);
    vec_t v;
    v = {v0, a0, d0, v1, a1, d1, r0, r1, wr, wreg, wdata, done};
    return v;
  endfunction

  task automatic drive(input logic v0, input logic [A-1:0] a0, input logic [W-1:0] d0,
                       input logic v1, input logic [A-1:0] a1, input logic [W-1:0] d1);
    req0_valid = v0; req0_addr = a0; req0_data = d0;
    req1_valid = v1; req1_addr = a1; req1_data = d1;
  endtask

  task automatic check_port(input string tag, input logic wr, input logic [A-1:0] wreg,
                            input logic [W-1:0] wdata, input logic done);
    check({tag, "_regwrite"}, 32'(reg_write), 32'(wr));
    check({tag, "_writereg"}, 32'(write_reg), 32'(wreg));
    check({tag, "_writedata"}, 32'(write_data), 32'(wdata));
    check({tag, "_initdone"}, 32'(init_done), 32'(done));
  endtask

  // Starts at a negedge with reset released; checks the zero-fill via exp_q,
  // then the first RUN cycle, and returns at the following negedge.
  task automatic run_clear(input string tag);
    logic [A-1:0] exp_reg;
    for (int k = 0; k < (1 << A); k++) exp_q.push_back(A'(k));
    for (int k = 0; k < (1 << A); k++) begin
      @(posedge clk); #1;
      exp_reg = exp_q.pop_front();
      check_port({tag, "_clear"}, 1'b1, exp_reg, '0, 1'b0);
    end
    @(posedge clk); #1;
    check({tag, "_end_regwrite"}, 32'(reg_write), 32'd0);
    check({tag, "_end_initdone"}, 32'(init_done), 32'd1);
    @(negedge clk);
  endtask

  initial begin
    // Stimulus table: inputs, expected readies, expected port after the edge
    //            v0 a0 d0    v1 a1 d1    r0 r1 wr reg data   done
    vecs.push_back(mk(1, 2, 4'h5, 1, 3, 4'h9, 0, 0, 1, 0, 4'h0, 0)); // INIT clear 0
    vecs.push_back(mk(1, 2, 4'h5, 1, 3, 4'h9, 0, 0, 1, 1, 4'h0, 0)); // clear 1
    vecs.push_back(mk(1, 2, 4'h5, 1, 3, 4'h9, 0, 0, 1, 2, 4'h0, 0)); // clear 2
    vecs.push_back(mk(1, 2, 4'h5, 1, 3, 4'h9, 0, 0, 1, 3, 4'h0, 0)); // clear 3
    vecs.push_back(mk(1, 2, 4'h5, 1, 3, 4'h9, 0, 0, 0, 3, 4'h0, 1)); // enter RUN
    vecs.push_back(mk(1, 2, 4'h5, 1, 3, 4'h9, 1, 0, 1, 2, 4'h5, 1)); // first grant req0
    vecs.push_back(mk(1, 2, 4'h5, 1, 3, 4'h9, 0, 1, 1, 3, 4'h9, 1)); // alternate
    vecs.push_back(mk(1, 2, 4'h5, 1, 3, 4'h9, 1, 0, 1, 2, 4'h5, 1));
    vecs.push_back(mk(1, 2, 4'h5, 1, 3, 4'h9, 0, 1, 1, 3, 4'h9, 1));
    vecs.push_back(mk(1, 1, 4'hA, 0, 0, 4'h0, 1, 0, 1, 1, 4'hA, 1)); // only req0
    vecs.push_back(mk(0, 0, 4'h0, 0, 0, 4'h0, 0, 0, 0, 1, 4'hA, 1)); // idle holds port
    vecs.push_back(mk(0, 0, 4'h0, 1, 0, 4'hF, 0, 1, 0, 1, 4'hA, 1)); // protected addr 0
    vecs.push_back(mk(0, 0, 4'h0, 1, 1, 4'h7, 0, 1, 1, 1, 4'h7, 1)); // only req1
    vecs.push_back(mk(1, 2, 4'h3, 1, 3, 4'h6, 1, 0, 1, 2, 4'h3, 1)); // ptr still 0
    vecs.push_back(mk(1, 1, 4'h1, 0, 0, 4'h0, 1, 0, 1, 1, 4'h1, 1)); // single ignores ptr
    vecs.push_back(mk(1, 2, 4'h4, 1, 3, 4'h8, 0, 1, 1, 3, 4'h8, 1)); // ptr=1 -> req1
    vecs.push_back(mk(1, 2, 4'h2, 1, 3, 4'h3, 1, 0, 1, 2, 4'h2, 1)); // ptr=0 -> req0

    // Reset state, with both requesters valid
    rst_n = 1'b0;
    drive(1, 2, 4'h5, 1, 3, 4'h9);
    repeat (2) @(negedge clk);
    check_port("reset", 1'b0, '0, '0, 1'b0);
    check("reset_ready", {30'd0, req0_ready, req1_ready}, 32'd0);
    check("reset_state", 32'(dbg_state), 32'd0);
    rst_n = 1'b1;

    // Table-driven vectors
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].v0, vecs[i].a0, vecs[i].d0, vecs[i].v1, vecs[i].a1, vecs[i].d1);
      #1;
      check($sformatf("v%0d_ready", i), {30'd0, req0_ready, req1_ready},
            {30'd0, vecs[i].r0, vecs[i].r1});
      @(posedge clk); #1;
      check_port($sformatf("v%0d", i), vecs[i].wr, vecs[i].wreg, vecs[i].wdata, vecs[i].done);
      @(negedge clk);
    end

    // Reset arriving after a transfer was accepted but before it reached the port
    drive(1, 1, 4'hC, 0, 0, 4'h0);
    #1;
    check("pend_ready", {30'd0, req0_ready, req1_ready}, 32'd2);
    #1;
    rst_n = 1'b0;
    #1;
    check_port("async_rst", 1'b0, '0, '0, 1'b0);
    check("async_rst_ready", {30'd0, req0_ready, req1_ready}, 32'd0);
    drive(0, 0, 4'h0, 0, 0, 4'h0);
    @(posedge clk); #1;
    check("rst_no_pulse", 32'(reg_write), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset in the middle of the clear sequence
    @(posedge clk); #1;
    check_port("midinit_c0", 1'b1, 2'd0, '0, 1'b0);
    @(posedge clk); #1;
    check_port("midinit_c1", 1'b1, 2'd1, '0, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    check_port("midinit_rst", 1'b0, '0, '0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    run_clear("restart");

    // The pointer was left at 1 before reset; after reset req0 wins first
    drive(1, 2, 4'h5, 1, 3, 4'h9);
    #1;
    check("post_rst_ready", {30'd0, req0_ready, req1_ready}, 32'd2);
    @(posedge clk); #1;
    check_port("post_rst", 1'b1, 2'd2, 4'h5, 1'b1);
    @(negedge clk);
    drive(0, 0, 4'h0, 0, 0, 4'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
